// File: rtl/synth_pkg.sv
// Shared synth definitions: note code width and tone encoding used by the
// sound-series player and the loop recorder.
package synth_pkg;

  localparam int NOTE_W = 4;

  typedef enum logic [NOTE_W-1:0] {
    C   = 4'h0,
    CS  = 4'h1,
    D   = 4'h2,
    DS  = 4'h3,
    E   = 4'h4,
    F   = 4'h5,
    FS  = 4'h6,
    G   = 4'h7,
    GS  = 4'h8,
    A   = 4'h9,
    AS  = 4'hA,
    B   = 4'hB,
    CH  = 4'hC,
    OFF = 4'hF
  } tone_t;

endpackage

// File: rtl/note_ram.sv
// Note buffer: synchronous write, asynchronous read, contents not reset.
module note_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/note_loop_recorder.sv
// Captures a live note stream one entry per note tick, then replays the take
// in a loop at the same tick rate.
module note_loop_recorder
  import synth_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clkdiv,
  input  logic              rec_edge,
  input  logic              play_edge,
  input  logic [NOTE_W-1:0] note_in,
  output logic [NOTE_W-1:0] note_out,
  output logic              recording,
  output logic              playing,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REC  = 2'd1,
    PLAY = 2'd2
  } rec_state_t;

  rec_state_t        state;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     length;
  logic [NOTE_W-1:0] ram_q;
  logic              we;

  // A tick only writes when no edge pulse is moving us out of REC this cycle.
  assign we = (state == REC) && clkdiv && !rec_edge && !play_edge;

  note_ram #(
    .DEPTH (DEPTH),
    .WIDTH (NOTE_W),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (note_in),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  assign recording = (state == REC);
  assign playing   = (state == PLAY);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      length   <= '0;
      note_out <= OFF;
      full     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rec_edge) begin
            state  <= REC;
            wr_ptr <= '0;
            length <= '0;
            full   <= 1'b0;
          end else if (play_edge && (length != '0)) begin
            state  <= PLAY;
            rd_ptr <= '0;
          end
        end

        REC: begin
          if (rec_edge) begin
            state <= IDLE;
          end else if (play_edge) begin
            if (length != '0) begin
              state  <= PLAY;
              rd_ptr <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (clkdiv) begin
            wr_ptr <= wr_ptr + 1'b1;
            length <= length + 1'b1;
            // The write that fills the last slot ends the take on the same edge.
            if (length == LW'(DEPTH - 1)) begin
              state <= IDLE;
              full  <= 1'b1;
            end
          end
        end

        PLAY: begin
          if (rec_edge) begin
            state    <= REC;
            wr_ptr   <= '0;
            length   <= '0;
            full     <= 1'b0;
            note_out <= OFF;
          end else if (play_edge) begin
            state    <= IDLE;
            note_out <= OFF;
          end else if (clkdiv) begin
            note_out <= ram_q;
            rd_ptr   <= ({1'b0, rd_ptr} == length - 1'b1) ? '0 : rd_ptr + 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          note_out <= OFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_loop_recorder.sv
// Self-checking bench for note_loop_recorder: queue-based take model compared
// every cycle, plus directed literal expectations.
module tb_note_loop_recorder;

  localparam int DEPTH = 64;

  logic       clk;
  logic       n_rst;
  logic       clkdiv;
  logic       rec_edge;
  logic       play_edge;
  logic [3:0] note_in;
  logic [3:0] note_out;
  logic       recording;
  logic       playing;
  logic       full;

  int errors = 0;
  int checks = 0;
  bit checking = 0;

  note_loop_recorder #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .clkdiv    (clkdiv),
    .rec_edge  (rec_edge),
    .play_edge (play_edge),
    .note_in   (note_in),
    .note_out  (note_out),
    .recording (recording),
    .playing   (playing),
    .full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the take is a queue of notes; mode 0=idle, 1=recording, 2=playing.
  int         m_mode = 0;
  logic [3:0] take[$];
  int         pidx = 0;
  logic [3:0] m_note = 4'hF;
  bit         m_full = 1'b0;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_mode = 0;
      take.delete();
      pidx   = 0;
      m_note = 4'hF;
      m_full = 1'b0;
    end else begin
      case (m_mode)
        0: begin
          if (rec_edge) begin
            m_mode = 1;
            take.delete();
            m_full = 1'b0;
          end else if (play_edge && take.size() > 0) begin
            m_mode = 2;
            pidx   = 0;
          end
        end
        1: begin
          if (rec_edge) m_mode = 0;
          else if (play_edge) begin
            m_mode = (take.size() > 0) ? 2 : 0;
            pidx   = 0;
          end else if (clkdiv) begin
            take.push_back(note_in);
            if (take.size() == DEPTH) begin
              m_mode = 0;
              m_full = 1'b1;
            end
          end
        end
        default: begin
          if (rec_edge) begin
            m_mode = 1;
            take.delete();
            m_full = 1'b0;
            m_note = 4'hF;
          end else if (play_edge) begin
            m_mode = 0;
            m_note = 4'hF;
          end else if (clkdiv) begin
            m_note = take[pidx];
            pidx   = (pidx + 1) % take.size();
          end
        end
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("model_note_out", {4'h0, note_out}, {4'h0, m_note});
      checkOutput("model_recording", {7'h0, recording}, {7'h0, m_mode == 1});
      checkOutput("model_playing", {7'h0, playing}, {7'h0, m_mode == 2});
      checkOutput("model_full", {7'h0, full}, {7'h0, m_full});
    end
  end

  // Drive one cycle's worth of inputs, then advance to the next falling edge.
  task automatic applyStimulus(input bit rec, input bit play, input bit tick, input logic [3:0] n);
    rec_edge  = rec;
    play_edge = play;
    clkdiv    = tick;
    note_in   = n;
    @(negedge clk);
    rec_edge  = 1'b0;
    play_edge = 1'b0;
    clkdiv    = 1'b0;
  endtask

  logic [3:0] take1 [5]  = '{4'h0, 4'h2, 4'h4, 4'hF, 4'h7};
  logic [3:0] exp2  [12] = '{4'h0, 4'h2, 4'h4, 4'hF, 4'h7, 4'h0,
                             4'h2, 4'h4, 4'hF, 4'h7, 4'h0, 4'h2};

  initial begin
    n_rst = 1'b0; clkdiv = 1'b0; rec_edge = 1'b0; play_edge = 1'b0; note_in = 4'hF;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    checking = 1'b1;
    checkOutput("reset_note_out", {4'h0, note_out}, 8'h0F);
    checkOutput("reset_playing", {7'h0, playing}, 8'h00);
    checkOutput("reset_full", {7'h0, full}, 8'h00);

    // Record C,D,E,OFF,G
    applyStimulus(1, 0, 0, 4'hF);
    checkOutput("t1_recording_on", {7'h0, recording}, 8'h01);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, take1[i]);
    applyStimulus(1, 0, 0, 4'hF);
    checkOutput("t1_recording_off", {7'h0, recording}, 8'h00);
    checkOutput("t1_full", {7'h0, full}, 8'h00);
    checkOutput("t1_length", {1'b0, dut.length}, 8'd5);

    // Looped playback, note_out OFF until the first tick
    applyStimulus(0, 1, 0, 4'hF);
    checkOutput("t2_playing", {7'h0, playing}, 8'h01);
    checkOutput("t2_note_before_tick", {4'h0, note_out}, 8'h0F);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 0, 1, 4'h1);
      checkOutput("t2_loop_note", {4'h0, note_out}, {4'h0, exp2[i]});
      applyStimulus(0, 0, 0, 4'h1);
    end
    applyStimulus(0, 1, 0, 4'hF);
    checkOutput("t2_stop_note", {4'h0, note_out}, 8'h0F);
    checkOutput("t2_stop_playing", {7'h0, playing}, 8'h00);

    // Fill all DEPTH slots
    applyStimulus(1, 0, 0, 4'hF);
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 1, 4'h9);
    checkOutput("t3_recording_off", {7'h0, recording}, 8'h00);
    checkOutput("t3_full", {7'h0, full}, 8'h01);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 4'h0);
    checkOutput("t3_length", {1'b0, dut.length}, 8'd64);
    applyStimulus(0, 1, 0, 4'hF);
    applyStimulus(0, 0, 1, 4'h0);
    checkOutput("t3_play_note", {4'h0, note_out}, 8'h09);
    // rec_edge while playing starts a fresh take
    applyStimulus(1, 0, 0, 4'hF);
    checkOutput("t3_rerec_note", {4'h0, note_out}, 8'h0F);
    checkOutput("t3_rerec_full", {7'h0, full}, 8'h00);
    for (int i = 1; i <= 3; i++) applyStimulus(0, 0, 1, 4'(i));
    applyStimulus(0, 1, 0, 4'hF);
    checkOutput("t3_rec_to_play", {7'h0, playing}, 8'h01);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, 4'hF);
      checkOutput("t3_short_loop", {4'h0, note_out}, 8'((i % 3) + 1));
    end
    applyStimulus(0, 1, 0, 4'hF);

    // Priority: rec beats play; rec beats tick
    applyStimulus(1, 1, 0, 4'hF);
    checkOutput("t4_rec_wins", {7'h0, recording}, 8'h01);
    applyStimulus(0, 0, 1, 4'hB);
    applyStimulus(0, 0, 1, 4'hC);
    applyStimulus(1, 0, 1, 4'h3);
    checkOutput("t4_rec_stop", {7'h0, recording}, 8'h00);
    checkOutput("t4_length", {1'b0, dut.length}, 8'd2);
    applyStimulus(0, 1, 0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 4'hF);
      checkOutput("t4_loop_note", {4'h0, note_out}, (i == 1) ? 8'h0C : 8'h0B);
    end
    applyStimulus(0, 1, 0, 4'hF);

    // Empty take cannot be played
    applyStimulus(1, 0, 0, 4'hF);
    applyStimulus(1, 0, 0, 4'hF);
    applyStimulus(0, 1, 0, 4'hF);
    checkOutput("t5_playing", {7'h0, playing}, 8'h00);
    checkOutput("t5_note", {4'h0, note_out}, 8'h0F);

    // Asynchronous reset mid-playback
    applyStimulus(1, 0, 0, 4'hF);
    for (int i = 1; i <= 5; i++) applyStimulus(0, 0, 1, 4'(i));
    applyStimulus(0, 1, 0, 4'hF);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 4'hF);
    checkOutput("t6_note_before_reset", {4'h0, note_out}, 8'h03);
    #2 n_rst = 1'b0;
    #1;
    checkOutput("t6_reset_note", {4'h0, note_out}, 8'h0F);
    checkOutput("t6_reset_playing", {7'h0, playing}, 8'h00);
    checkOutput("t6_reset_length", {1'b0, dut.length}, 8'd0);
    @(negedge clk);
    n_rst = 1'b1;
    applyStimulus(0, 1, 0, 4'hF);
    checkOutput("t6_play_after_reset", {7'h0, playing}, 8'h00);
    applyStimulus(0, 0, 1, 4'hF);
    applyStimulus(0, 0, 0, 4'hF);

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
